ins_writeback: RTL and testbench

//  Commit/writeback stage downstream of the execute stage. Accepts one execute result per handshake:

---
 rtl/ins_writeback.sv | 214 +++++++++++++++++++++
 tb/tb_ins_writeback.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_writeback.sv
// ============================================================================
// Module   : ins_writeback
// Purpose  : Commit/writeback stage. Takes one execute result per handshake
//            and applies its register-file write and PC update one cycle
//            later. Stores go into an in-order store buffer that drains to
//            the data bus over a req/ack handshake.
// Ports    : sys_clk/sys_rst_n         clock, async active-low reset
//            ex_valid/ex_ready         result handshake (ready = buffer not full)
//            reg_w_*, mem_w_*, reg_pc_w_* result fields
//            rf_we/rf_waddr/rf_wdata   register-file write (1-cycle pulse)
//            pc_we/pc_wdata            PC write (1-cycle pulse)
//            bus_req/bus_addr/bus_wdata/bus_ack  store drain handshake
//            sb_busy                   store buffer non-empty
//            ld_addr/ld_hit/ld_data    store-to-load forwarding lookup
//                                      (only with INS_WB_STORE_FWD_EN defined)
// Config   : INS_WB_STORE_FWD_EN enables the forwarding lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_writeback #(
  parameter int SB_DEPTH = 4,
  parameter int DATA_W   = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              reg_w_op,
  input  logic [4:0]        reg_w_reg_idx,
  input  logic [DATA_W-1:0] reg_w_reg_val,
  input  logic              mem_w_op,
  input  logic [DATA_W-1:0] mem_w_mem_addr,
  input  logic [DATA_W-1:0] mem_w_mem_val,
  input  logic              reg_pc_w_op,
  input  logic [DATA_W-1:0] reg_pc_w_val,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              bus_req,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
`ifdef INS_WB_STORE_FWD_EN
  input  logic [DATA_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
`endif
  output logic              sb_busy
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Store buffer storage and bookkeeping
  logic [DATA_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  sb_count_q, sb_count_d;

  state_e            state_q;
  logic              bus_req_q;
  logic [DATA_W-1:0] bus_addr_q, bus_wdata_q;

  logic              rf_we_q, pc_we_q;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q, pc_wdata_q;

  logic              accept, push, pop;

  // ---------------------------------------------------------------------------
  // Handshake and buffer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_ready   = (sb_count_q < CNT_W'(SB_DEPTH));
    accept     = ex_valid && ex_ready;
    push       = accept && mem_w_op;
    // A pop can only happen while a request is actually on the bus, so a
    // stray ack in S_IDLE has no effect.
    pop        = (state_q == S_REQ) && bus_ack;
    wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    sb_count_d = sb_count_q;
    case ({push, pop})
      2'b10:   sb_count_d = sb_count_q + CNT_W'(1);
      2'b01:   sb_count_d = sb_count_q - CNT_W'(1);
      default: sb_count_d = sb_count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sb_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sb_count_q <= sb_count_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the count/pointers.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      sb_addr_q[wr_ptr_q] <= mem_w_mem_addr;
      sb_data_q[wr_ptr_q] <= mem_w_mem_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file and PC write strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_we_q    <= 1'b0;
      pc_wdata_q <= '0;
    end else begin
      // x0 is hard-wired zero, so writes to it are dropped here.
      rf_we_q <= accept && reg_w_op && (reg_w_reg_idx != 5'd0);
      if (accept && reg_w_op && (reg_w_reg_idx != 5'd0)) begin
        rf_waddr_q <= reg_w_reg_idx;
        rf_wdata_q <= reg_w_reg_val;
      end
      pc_we_q <= accept && reg_pc_w_op;
      if (accept && reg_pc_w_op) begin
        pc_wdata_q <= reg_pc_w_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM: bus address/data are registered copies of the head entry,
  // loaded when a request starts or advances, so they stay stable while
  // bus_req is high regardless of pushes into the buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sb_count_q != '0) begin
            state_q     <= S_REQ;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= sb_addr_q[rd_ptr_q];
            bus_wdata_q <= sb_data_q[rd_ptr_q];
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            if (sb_count_q > CNT_W'(1)) begin
              // Back-to-back: rd_ptr_d already points at the next entry.
              bus_addr_q  <= sb_addr_q[rd_ptr_d];
              bus_wdata_q <= sb_data_q[rd_ptr_d];
            end else begin
              state_q   <= S_IDLE;
              bus_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef INS_WB_STORE_FWD_EN
  // Scan from oldest to newest; a later (newer) match overrides an earlier
  // one. The head entry counts even while it is being popped.
  logic [PTR_W-1:0] fwd_idx;
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < sb_count_q) && (sb_addr_q[fwd_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = sb_data_q[fwd_idx];
      end
    end
  end
`endif

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc_we     = pc_we_q;
  assign pc_wdata  = pc_wdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign sb_busy   = (sb_count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_ins_writeback.sv
// ============================================================================
// Module   : tb_ins_writeback
// Purpose  : Self-checking bench for ins_writeback. A driver issues directed
//            and random results; a monitor keeps a queue-based model of the
//            store buffer and pending register/PC writes and compares every
//            DUT output against it each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_writeback;

  localparam int DEPTH = 4;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        ex_valid, ex_ready;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        mem_w_op;
  logic [31:0] mem_w_mem_addr, mem_w_mem_val;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        bus_req, bus_ack;
  logic [31:0] bus_addr, bus_wdata;
  logic        sb_busy;
`ifdef INS_WB_STORE_FWD_EN
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit;
`endif

  ins_writeback #(.SB_DEPTH(DEPTH), .DATA_W(32)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .reg_w_op       (reg_w_op),
    .reg_w_reg_idx  (reg_w_reg_idx),
    .reg_w_reg_val  (reg_w_reg_val),
    .mem_w_op       (mem_w_op),
    .mem_w_mem_addr (mem_w_mem_addr),
    .mem_w_mem_val  (mem_w_mem_val),
    .reg_pc_w_op    (reg_pc_w_op),
    .reg_pc_w_val   (reg_pc_w_val),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .pc_we          (pc_we),
    .pc_wdata       (pc_wdata),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
`ifdef INS_WB_STORE_FWD_EN
    .ld_addr        (ld_addr),
    .ld_hit         (ld_hit),
    .ld_data        (ld_data),
`endif
    .sb_busy        (sb_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] val;
  } wr_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  wr_exp_t rf_q[$];
  wr_exp_t pc_q[$];
  st_t     sb_q[$];      // model of the buffer contents, oldest first

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int lat_cyc = -1;      // cycle a store entered an empty buffer
  int req_cyc = -1;      // cycle at which bus_req_exp applies
  logic bus_req_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: checks on the falling edge, then advances the model for the
  // coming rising edge.
  // ---------------------------------------------------------------------------
  always begin
    @(negedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      #1;
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_sb_busy", {31'd0, sb_busy}, 32'd0);
      chk("rst_rf_we",   {31'd0, rf_we},   32'd0);
      chk("rst_pc_we",   {31'd0, pc_we},   32'd0);
      chk("rst_ex_ready",{31'd0, ex_ready},32'd1);
      chk("rst_bus_addr", bus_addr, 32'd0);
      sb_q.delete();
      rf_q.delete();
      pc_q.delete();
      lat_cyc = -1;
      req_cyc = -1;
    end else begin
      bit acc;
      bit pop;
      cyc++;
      chk("ex_ready", {31'd0, ex_ready}, {31'd0, (sb_q.size() < DEPTH)});
      chk("sb_busy",  {31'd0, sb_busy},  {31'd0, (sb_q.size() != 0)});

      while (rf_q.size() != 0 && rf_q[0].cyc < cyc) begin
        chk("rf_we_missing", {31'd0, rf_we}, 32'd1);
        void'(rf_q.pop_front());
      end
      if (rf_we) begin
        if (rf_q.size() != 0 && rf_q[0].cyc == cyc) begin
          chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, rf_q[0].idx});
          chk("rf_wdata", rf_wdata, rf_q[0].val);
          void'(rf_q.pop_front());
        end else begin
          chk("rf_we_spurious", {31'd0, rf_we}, 32'd0);
        end
      end

      while (pc_q.size() != 0 && pc_q[0].cyc < cyc) begin
        chk("pc_we_missing", {31'd0, pc_we}, 32'd1);
        void'(pc_q.pop_front());
      end
      if (pc_we) begin
        if (pc_q.size() != 0 && pc_q[0].cyc == cyc) begin
          chk("pc_wdata", pc_wdata, pc_q[0].val);
          void'(pc_q.pop_front());
        end else begin
          chk("pc_we_spurious", {31'd0, pc_we}, 32'd0);
        end
      end

      if (bus_req) begin
        chk("bus_req_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
          chk("bus_addr",  bus_addr,  sb_q[0].addr);
          chk("bus_wdata", bus_wdata, sb_q[0].data);
        end
      end

      if (req_cyc == cyc) begin
        chk("bus_req_after_ack", {31'd0, bus_req}, {31'd0, bus_req_exp});
        req_cyc = -1;
      end
      if (lat_cyc >= 0 && cyc == lat_cyc + 1)
        chk("bus_req_lat1", {31'd0, bus_req}, 32'd0);
      if (lat_cyc >= 0 && cyc == lat_cyc + 2) begin
        chk("bus_req_lat2", {31'd0, bus_req}, 32'd1);
        lat_cyc = -1;
      end

`ifdef INS_WB_STORE_FWD_EN
      begin
        bit          hit;
        logic [31:0] d;
        hit = 1'b0;
        d   = '0;
        foreach (sb_q[i]) if (sb_q[i].addr == ld_addr) begin hit = 1'b1; d = sb_q[i].data; end
        chk("ld_hit", {31'd0, ld_hit}, {31'd0, hit});
        if (hit) chk("ld_data", ld_data, d);
      end
`endif

      // Advance the model to the upcoming rising edge.
      pop = bus_req && bus_ack && (sb_q.size() != 0);
      acc = ex_valid && (sb_q.size() < DEPTH);
      if (pop) begin
        req_cyc     = cyc + 1;
        bus_req_exp = (sb_q.size() > 1);
      end
      if (acc && reg_w_op && reg_w_reg_idx != 5'd0)
        rf_q.push_back('{cyc + 1, reg_w_reg_idx, reg_w_reg_val});
      if (acc && reg_pc_w_op)
        pc_q.push_back('{cyc + 1, 5'd0, reg_pc_w_val});
      if (acc && mem_w_op && sb_q.size() == 0 && !pop)
        lat_cyc = cyc;
      if (pop) void'(sb_q.pop_front());
      if (acc && mem_w_op) sb_q.push_back('{mem_w_mem_addr, mem_w_mem_val});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid       = 1'b0;
    reg_w_op       = 1'b0;
    reg_w_reg_idx  = '0;
    reg_w_reg_val  = '0;
    mem_w_op       = 1'b0;
    mem_w_mem_addr = '0;
    mem_w_mem_val  = '0;
    reg_pc_w_op    = 1'b0;
    reg_pc_w_val   = '0;
  endtask

  task automatic drive(input logic rw, input logic [4:0] idx, input logic [31:0] rv,
                       input logic mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic pw, input logic [31:0] pv);
    ex_valid       = 1'b1;
    reg_w_op       = rw;
    reg_w_reg_idx  = idx;
    reg_w_reg_val  = rv;
    mem_w_op       = mw;
    mem_w_mem_addr = ma;
    mem_w_mem_val  = md;
    reg_pc_w_op    = pw;
    reg_pc_w_val   = pv;
  endtask

  // Present a store and hold it until the stage is ready (bounded).
  task automatic send_store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 5'd0, 32'd0, 1'b1, a, d, 1'b0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (ex_ready) break;
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b1;
    bus_ack   = 1'b0;
    set_idle();
`ifdef INS_WB_STORE_FWD_EN
    ld_addr = '0;
`endif
    #2 sys_rst_n = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(1);

    // Register write, then a write to x0 which must be dropped.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 0, 0, 1'b0, 0);
    step(1); set_idle(); step(2);
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 0, 0, 1'b0, 0);
    step(1); set_idle(); step(2);

    // PC and register write from one result.
    drive(1'b1, 5'd1, 32'h7C, 1'b0, 0, 0, 1'b1, 32'h80);
    step(1); set_idle(); step(2);

    // Fill the buffer with ack low; a fifth store must be refused.
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 0, 1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0, 0);
      step(1);
    end
    drive(1'b0, 5'd0, 0, 1'b1, 32'h110, 32'd5, 1'b0, 0);
    step(2);
    set_idle();
    bus_ack = 1'b1;
    step(8);

    // Full buffer draining while new stores arrive: pointers wrap.
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) send_store(32'h300 + 32'(4 * i), 32'h11 + 32'(i));
    bus_ack = 1'b1;
    for (int i = 4; i < 9; i++) send_store(32'h300 + 32'(4 * i), 32'h11 + 32'(i));
    set_idle();
    step(10);

    // Random traffic with random ack.
    for (int i = 0; i < 400; i++) begin
      bus_ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(1'(($urandom_range(0, 1))), 5'($urandom_range(0, 31)), $urandom,
              1'(($urandom_range(0, 1))), 32'h400 + 32'(4 * $urandom_range(0, 7)), $urandom,
              1'(($urandom_range(0, 3) == 0)), $urandom);
      else
        set_idle();
`ifdef INS_WB_STORE_FWD_EN
      ld_addr = 32'h400 + 32'(4 * $urandom_range(0, 8));
`endif
      step(1);
    end
    set_idle();
    bus_ack = 1'b1;
    step(10);

`ifdef INS_WB_STORE_FWD_EN
    // Two stores to one address: the newer one must be forwarded.
    bus_ack = 1'b0;
    send_store(32'h200, 32'hA);
    send_store(32'h200, 32'hB);
    set_idle();
    ld_addr = 32'h200;
    step(2);
    ld_addr = 32'h204;
    step(2);
    bus_ack = 1'b1;
    step(6);
`endif

    // Reset in the middle of a pending store: nothing may be issued after.
    bus_ack = 1'b0;
    send_store(32'h500, 32'h55);
    set_idle();
    step(4);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    bus_ack = 1'b1;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
